// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered RV32I branch resolution with 2-bit BHT and perf counters
module branch_resolve_unit #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CTR_INIT    = 2'b01,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             rs_valid,
  output logic             rs_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [12:0]      imm,
  input  logic [XLEN-1:0]  in1,
  input  logic [XLEN-1:0]  in2,
  input  logic [XLEN-1:0]  pc,
  input  logic             pred_taken_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  iaddr,
  output logic             taken,
  output logic             mispredict,
  output logic             illegal,
  output logic [CNT_W-1:0] n_branches,
  output logic [CNT_W-1:0] n_mispredicts
);
  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic             out_valid_q, taken_q, mispredict_q, illegal_q;
  logic [XLEN-1:0]  iaddr_q;
  logic [CNT_W-1:0] n_br_q, n_mis_q;

  logic             is_br, ill_d, legal_d, cond_d, taken_d, mispredict_d, accept;
  logic [XLEN-1:0]  target_d, seq_d, iaddr_d;
  logic [IDX-1:0]   upd_idx;

  wire unused_ok = &{1'b0, imm[0], pred_pc[XLEN-1:IDX+2], pred_pc[1:0], pc[1:0]};

  assign pred_taken = bht_q[pred_pc[IDX+1:2]][1];
  assign rs_ready   = !out_valid_q || out_ready;
  assign accept     = rs_valid && rs_ready;
  assign upd_idx    = pc[IDX+1:2];

  always_comb begin
    cond_d = 1'b0;
    case (funct3)
      3'b000:  cond_d = (in1 == in2);
      3'b001:  cond_d = (in1 != in2);
      3'b100:  cond_d = ($signed(in1) < $signed(in2));
      3'b101:  cond_d = !($signed(in1) < $signed(in2));
      3'b110:  cond_d = (in1 < in2);
      3'b111:  cond_d = !(in1 < in2);
      default: cond_d = 1'b0;
    endcase
  end

  assign is_br        = (opcode == 7'b1100011);
  assign ill_d        = is_br && (funct3[2:1] == 2'b01);
  assign legal_d      = is_br && !ill_d;
  assign taken_d      = legal_d && cond_d;
  assign mispredict_d = legal_d && (taken_d ^ pred_taken_in);
  assign target_d     = pc + {{(XLEN-13){imm[12]}}, imm[12:1], 1'b0};
  assign seq_d        = pc + XLEN'(4);
  assign iaddr_d      = taken_d ? target_d : seq_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_INIT;
      out_valid_q   <= 1'b0;
      iaddr_q       <= '0;
      taken_q       <= 1'b0;
      mispredict_q  <= 1'b0;
      illegal_q     <= 1'b0;
      n_br_q        <= '0;
      n_mis_q       <= '0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      iaddr_q      <= iaddr_d;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
      illegal_q    <= ill_d;
      if (legal_d) begin
        // 2-bit saturating training: only legal branches touch the table or perf counters
        if (taken_d && bht_q[upd_idx] != 2'b11)
          bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
        else if (!taken_d && bht_q[upd_idx] != 2'b00)
          bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
        if (n_br_q != '1) n_br_q <= n_br_q + 1'b1;
        if (mispredict_d && n_mis_q != '1) n_mis_q <= n_mis_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid     = out_valid_q;
  assign iaddr         = iaddr_q;
  assign taken         = taken_q;
  assign mispredict    = mispredict_q;
  assign illegal       = illegal_q;
  assign n_branches    = n_br_q;
  assign n_mispredicts = n_mis_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
  localparam logic [6:0] BR = 7'b1100011;

  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_taken, rs_valid = 1'b0, rs_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [12:0] imm = '0;
  logic [31:0] in1 = '0, in2 = '0, pc = '0;
  logic        pred_taken_in = 1'b0, out_valid, out_ready = 1'b1;
  logic [31:0] iaddr;
  logic        taken, mispredict, illegal;
  logic [15:0] n_branches, n_mispredicts;
  int errors = 0, checks = 0;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .opcode(opcode), .funct3(funct3),
    .imm(imm), .in1(in1), .in2(in2), .pc(pc), .pred_taken_in(pred_taken_in),
    .out_valid(out_valid), .out_ready(out_ready), .iaddr(iaddr), .taken(taken),
    .mispredict(mispredict), .illegal(illegal), .n_branches(n_branches),
    .n_mispredicts(n_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic set_req(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, input logic [12:0] im,
                         input logic pti);
    opcode = op; funct3 = f3; in1 = a; in2 = b; pc = p; imm = im; pred_taken_in = pti;
    rs_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rs_valid = 1'b0; out_ready = 1'b1;
    #2 rst = 1'b1; #3 rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; #3;
    pred_pc = 32'h100; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred got=%b exp=0", pred_taken); end
    pred_pc = 32'hABC; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred2 got=%b exp=0", pred_taken); end
    checks++; if ({out_valid, taken, mispredict, illegal} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {out_valid, taken, mispredict, illegal}); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr got=%h exp=0", iaddr); end
    checks++; if ({n_branches, n_mispredicts} !== 32'h0) begin errors++; $display("FAIL reset_perf got=%h exp=0", {n_branches, n_mispredicts}); end
    checks++; if (rs_ready !== 1'b1) begin errors++; $display("FAIL reset_rs_ready got=%b exp=1", rs_ready); end
    rst = 1'b0; #1;
  endtask

  task automatic test_beq();
    pred_pc = 32'h100;
    set_req(BR, 3'b000, 32'd1, 32'd1, 32'h100, 13'h010, 1'b0); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL beq_pred_before got=%b exp=0", pred_taken); end
    step(); rs_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL beq_valid got=%b exp=1", out_valid); end
    checks++; if (iaddr !== 32'h110) begin errors++; $display("FAIL beq_iaddr got=%h exp=110", iaddr); end
    checks++; if ({taken, mispredict, illegal} !== 3'b110) begin errors++; $display("FAIL beq_flags got=%b exp=110", {taken, mispredict, illegal}); end
    checks++; if (n_mispredicts !== 16'd1 || n_branches !== 16'd1) begin errors++; $display("FAIL beq_perf got=%0d/%0d exp=1/1", n_branches, n_mispredicts); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL beq_pred_after got=%b exp=1", pred_taken); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL beq_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_signed_unsigned();
    set_req(BR, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 13'h1FF0, 1'b1);
    step();
    checks++; if (iaddr !== 32'h1F0 || taken !== 1'b1) begin errors++; $display("FAIL blt got=%h/%b exp=1f0/1", iaddr, taken); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL blt_mis got=%b exp=0", mispredict); end
    set_req(BR, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 13'h1FF0, 1'b1);
    step(); rs_valid = 1'b0;
    checks++; if (iaddr !== 32'h204 || taken !== 1'b0) begin errors++; $display("FAIL bltu got=%h/%b exp=204/0", iaddr, taken); end
    checks++; if (mispredict !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL bltu_mis got=%b/%b exp=1/1", mispredict, out_valid); end
    checks++; if (n_branches !== 16'd3 || n_mispredicts !== 16'd2) begin errors++; $display("FAIL su_perf got=%0d/%0d exp=3/2", n_branches, n_mispredicts); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_req(BR, 3'b001, 32'd5, 32'd5, 32'h500, 13'h020, 1'b0);
    step();
    checks++; if (out_valid !== 1'b1 || iaddr !== 32'h504 || rs_ready !== 1'b0) begin errors++; $display("FAIL bp_first got=%b/%h/%b exp=1/504/0", out_valid, iaddr, rs_ready); end
    set_req(BR, 3'b000, 32'd7, 32'd7, 32'h600, 13'h1000, 1'b1);
    step();
    checks++; if (iaddr !== 32'h504 || taken !== 1'b0 || rs_ready !== 1'b0) begin errors++; $display("FAIL bp_hold got=%h/%b/%b exp=504/0/0", iaddr, taken, rs_ready); end
    checks++; if (n_branches !== 16'd4) begin errors++; $display("FAIL bp_no_accept got=%0d exp=4", n_branches); end
    out_ready = 1'b1; #1;
    checks++; if (rs_ready !== 1'b1) begin errors++; $display("FAIL bp_ready got=%b exp=1", rs_ready); end
    step(); rs_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || iaddr !== 32'hFFFF_F600 || taken !== 1'b1) begin errors++; $display("FAIL bp_second got=%b/%h/%b exp=1/fffff600/1", out_valid, iaddr, taken); end
    checks++; if (n_branches !== 16'd5) begin errors++; $display("FAIL bp_count got=%0d exp=5", n_branches); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    pred_pc = 32'h300;
    for (int i = 0; i < 5; i++) begin
      set_req(BR, 3'b000, 32'd9, 32'd9, 32'h300, 13'h040, 1'b1);
      step();
    end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_taken got=%b exp=1", pred_taken); end
    set_req(BR, 3'b001, 32'd9, 32'd9, 32'h300, 13'h040, 1'b1);
    step();
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_one_nt got=%b exp=1", pred_taken); end
    checks++; if (n_branches !== 16'd6 || n_mispredicts !== 16'd1) begin errors++; $display("FAIL sat_perf got=%0d/%0d exp=6/1", n_branches, n_mispredicts); end
    step();
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_two_nt got=%b exp=0", pred_taken); end
    checks++; if (n_branches !== 16'd7 || n_mispredicts !== 16'd2) begin errors++; $display("FAIL sat_perf2 got=%0d/%0d exp=7/2", n_branches, n_mispredicts); end
    rs_valid = 1'b0; step();
  endtask

  task automatic test_nonbranch_illegal();
    set_req(7'b0000000, 3'b000, 32'd3, 32'd3, 32'hFFFF_FFFC, 13'h010, 1'b1);
    step();
    checks++; if (iaddr !== 32'h0 || {taken, mispredict, illegal} !== 3'b000) begin errors++; $display("FAIL nonbr got=%h/%b exp=0/000", iaddr, {taken, mispredict, illegal}); end
    pred_pc = 32'h0;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL nonbr_ctr got=%b exp=0", pred_taken); end
    set_req(BR, 3'b010, 32'd3, 32'd3, 32'h400, 13'h010, 1'b1);
    step(); rs_valid = 1'b0;
    checks++; if (iaddr !== 32'h404 || {taken, mispredict, illegal} !== 3'b001) begin errors++; $display("FAIL illegal got=%h/%b exp=404/001", iaddr, {taken, mispredict, illegal}); end
    checks++; if (n_branches !== 16'd7 || n_mispredicts !== 16'd2) begin errors++; $display("FAIL illegal_perf got=%0d/%0d exp=7/2", n_branches, n_mispredicts); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL illegal_ctr got=%b exp=0", pred_taken); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    pred_pc = 32'h700;
    set_req(BR, 3'b000, 32'd1, 32'd1, 32'h700, 13'h010, 1'b0);
    step(); rs_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || pred_taken !== 1'b1) begin errors++; $display("FAIL mid_pre got=%b/%b exp=1/1", out_valid, pred_taken); end
    #2 rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || iaddr !== 32'h0 || n_branches !== 16'd0 || pred_taken !== 1'b0) begin errors++; $display("FAIL mid_reset got=%b/%h/%0d/%b exp=0/0/0/0", out_valid, iaddr, n_branches, pred_taken); end
    rst = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_beq();
    test_signed_unsigned();
    test_back_to_back();
    test_saturation();
    test_nonbranch_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
